// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and constants for the GPU compositor.
// CSR offsets, reset values and the RGB444 colour type.
package gpu_pkg;

  localparam int COLOR_W = 12;

  typedef logic [COLOR_W-1:0] color_t;

  localparam logic [15:0] CSR_BG     = 16'd0;
  localparam logic [15:0] CSR_KEY    = 16'd1;
  localparam logic [15:0] CSR_MASK   = 16'd2;
  localparam logic [15:0] CSR_COMMIT = 16'd3;

  localparam color_t RST_BG  = 12'h8CE;
  localparam color_t RST_KEY = 12'hFFF;

  typedef struct packed {
    color_t bg;
    color_t key;
  } cfg_t;

endpackage

// File: rtl/gpu_layer_prio.sv
// gpu_layer_prio: combinational priority select of layer pixels.
// Lowest enabled, non-keyed layer wins; background otherwise.
module gpu_layer_prio
  import gpu_pkg::*;
#(
  parameter int LAYER_COUNT = 5
) (
  input  logic [LAYER_COUNT*COLOR_W-1:0] pixels,
  input  logic [LAYER_COUNT-1:0]         mask,
  input  color_t                         key,
  input  color_t                         bg,
  output color_t                         color
);

  // walk from lowest priority up so layer 0 overrides last
  always_comb begin
    color = bg;
    for (int i = LAYER_COUNT - 1; i >= 0; i--) begin
      if (mask[i] && (pixels[i*COLOR_W +: COLOR_W] != key))
        color = pixels[i*COLOR_W +: COLOR_W];
    end
  end

endmodule

// File: rtl/gpu_compositor.sv
// gpu_compositor: host write routing, double-buffered CSRs and
// a two-strobe priority compositing pipe with matched syncs.
module gpu_compositor
  import gpu_pkg::*;
#(
  parameter int LAYER_COUNT     = 5,
  parameter int COLOR_WIDTH     = 12,
  parameter int ADDR_WIDTH      = 24,
  parameter int DATA_WIDTH      = 32,
  parameter int LAYER_ADDR_SIZE = 4192,
  parameter int LAYER_AW        = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pix_en,
  input  logic [ADDR_WIDTH-1:0]              waddr,
  input  logic [DATA_WIDTH-1:0]              wdata,
  input  logic                               wen,
  output logic [LAYER_AW-1:0]                layer_waddr,
  output logic [15:0]                        layer_wdata,
  output logic [LAYER_COUNT-1:0]             layer_wen,
  input  logic [LAYER_COUNT*COLOR_WIDTH-1:0] layer_pixel,
  input  logic                               visible_in,
  input  logic                               hsync_in,
  input  logic                               vsync_in,
  output logic [3:0]                         red,
  output logic [3:0]                         green,
  output logic [3:0]                         blue,
  output logic                               hsync,
  output logic                               vsync,
  output logic [15:0]                        frame_cnt
);

  localparam logic [15:0] LC16 = 16'(LAYER_COUNT);
  localparam logic [15:0] LAS16 = 16'(LAYER_ADDR_SIZE);

  logic [15:0] word, sel, off;
  logic        csr_wr, commit_wr, vs_prev, vs_fall, commit_pend;
  logic        unused;

  cfg_t                   cfg_pend, cfg_act;
  logic [LAYER_COUNT-1:0] mask_pend, mask_act;

  logic [LAYER_COUNT*COLOR_WIDTH-1:0] s1_pix;
  logic   s1_vis, s1_hs, s1_vs;
  color_t prio_color, rgb;

  assign word      = waddr[17:2];
  assign sel       = word / LAS16;
  assign off       = word % LAS16;
  assign csr_wr    = wen && (sel == LC16);
  assign commit_wr = csr_wr && (off == CSR_COMMIT);
  assign vs_fall   = vs_prev && !vsync_in;
  assign unused    = ^{waddr[ADDR_WIDTH-1:18], waddr[1:0],
                       wdata[DATA_WIDTH-1:16]};

  assign red   = rgb[11:8];
  assign green = rgb[7:4];
  assign blue  = rgb[3:0];

  // register layer write strobe, offset and data
  always_ff @(posedge clk) begin
    if (!rst) begin
      layer_wen   <= '0;
      layer_waddr <= '0;
      layer_wdata <= '0;
    end else begin
      for (int i = 0; i < LAYER_COUNT; i++)
        layer_wen[i] <= wen && (sel == 16'(i));
      layer_waddr <= LAYER_AW'(off);
      layer_wdata <= wdata[15:0];
    end
  end

  // pending/active CSR banks, commit on vsync fall
  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_pend    <= '{bg: RST_BG, key: RST_KEY};
      cfg_act     <= '{bg: RST_BG, key: RST_KEY};
      mask_pend   <= '1;
      mask_act    <= '1;
      commit_pend <= 1'b0;
      frame_cnt   <= '0;
      vs_prev     <= 1'b1;
    end else begin
      vs_prev <= vsync_in;
      if (csr_wr && off == CSR_BG)
        cfg_pend.bg <= wdata[11:0];
      if (csr_wr && off == CSR_KEY)
        cfg_pend.key <= wdata[11:0];
      if (csr_wr && off == CSR_MASK)
        mask_pend <= wdata[LAYER_COUNT-1:0];
      if (vs_fall && commit_pend) begin
        cfg_act     <= cfg_pend;
        mask_act    <= mask_pend;
        frame_cnt   <= frame_cnt + 16'd1;
        commit_pend <= commit_wr;
      end else if (commit_wr) begin
        commit_pend <= 1'b1;
      end
    end
  end

  gpu_layer_prio #(
    .LAYER_COUNT(LAYER_COUNT)
  ) u_prio (
    .pixels(s1_pix),
    .mask  (mask_act),
    .key   (cfg_act.key),
    .bg    (cfg_act.bg),
    .color (prio_color)
  );

  // two-strobe pixel pipe; syncs ride alongside the colour
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_pix <= '0;
      s1_vis <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      rgb    <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else if (pix_en) begin
      s1_pix <= layer_pixel;
      s1_vis <= visible_in;
      s1_hs  <= hsync_in;
      s1_vs  <= vsync_in;
      rgb    <= s1_vis ? prio_color : '0;
      hsync  <= s1_hs;
      vsync  <= s1_vs;
    end
  end

endmodule
